// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding (which is
// also the externally visible `state` port), restart counter width and a
// helper that sizes the internal counters.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_RESET     = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam int RESTART_CNT_W = 8;

    // Counter width for a count range of 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// Button conditioning: synchronizes the asynchronous active-low button and
// accepts a new level only after it has been stable for DEBOUNCE_CYCLES.
// press is a one-cycle pulse coincident with the debounced level falling.
module rst_seq_debounce
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_db,
    output logic press
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   btn_s;
    logic [DW-1:0]          db_cnt;

    // Synchronizer chain for the raw button; clears to 0 like every other sync flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_n};
        end
    end

    assign btn_s = btn_sync[SYNC_STAGES-1];

    // Debounce: count consecutive disagreeing cycles, any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s != btn_db) begin
                if (db_cnt == DB_LAST) begin
                    btn_db <= btn_s;
                    db_cnt <= '0;
                    press  <= btn_db & ~btn_s;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Reset / clock-qualification sequencer upstream of the blink core.
// Waits for a stable PLL lock, holds reset for HOLD_CYCLES, then releases
// rst_out_n and emits a tick every TICK_DIV cycles while running. Lock loss
// or a debounced button press returns to lock qualification.
// Optional build macro RST_SEQ_RESTART_CNT_EN enables the saturating count of
// RUN exits on restart_cnt; without it restart_cnt is tied to zero.
module rst_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 8,
    parameter int HOLD_CYCLES        = 32,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int TICK_DIV           = 1000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pll_locked,
    input  logic                                  btn_n,
    output logic                                  rst_out_n,
    output logic                                  tick,
    output logic [1:0]                            state,
    output logic [rst_seq_pkg::RESTART_CNT_W-1:0] restart_cnt
);

    import rst_seq_pkg::*;

    localparam int LW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t                 cur_state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    logic                   btn_db;
    logic                   press;
    logic                   btn_press;
    logic [LW-1:0]          lock_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [TW-1:0]          tick_div;

    rst_seq_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_n  (btn_n),
        .btn_db (btn_db),
        .press  (press)
    );

    // A press only counts while the accepted button level is actually low.
    assign btn_press = press & ~btn_db;

    // Synchronizer chain for the PLL lock indication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

    // Next-state decision; a press restarts the current qualification step.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S_RESET:     next_state = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (!btn_press && lock_s && (lock_cnt == LOCK_LAST)) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!lock_s) begin
                    next_state = S_WAIT_LOCK;
                end else if (!btn_press && (hold_cnt == HOLD_LAST)) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s || btn_press) begin
                    next_state = S_WAIT_LOCK;
                end
            end
            default:     next_state = S_RESET;
        endcase
    end

    // FSM state, qualification counters and the registered downstream reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_RESET;
            lock_cnt  <= '0;
            hold_cnt  <= '0;
            rst_out_n <= 1'b0;
        end else begin
            cur_state <= next_state;
            rst_out_n <= (next_state == S_RUN);
            if ((cur_state == S_WAIT_LOCK) && (next_state == S_WAIT_LOCK) && lock_s && !btn_press) begin
                lock_cnt <= lock_cnt + LW'(1);
            end else begin
                lock_cnt <= '0;
            end
            if ((cur_state == S_HOLD) && (next_state == S_HOLD) && !btn_press) begin
                hold_cnt <= hold_cnt + HW'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Tick divider: free-runs only in RUN, and a tick is suppressed on the exit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_div <= '0;
            tick     <= 1'b0;
        end else if (cur_state != S_RUN) begin
            tick_div <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_div == TICK_LAST) && (next_state == S_RUN);
            tick_div <= (tick_div == TICK_LAST) ? '0 : tick_div + TW'(1);
        end
    end

`ifdef RST_SEQ_RESTART_CNT_EN
    // Saturating count of RUN exits; a simultaneous lock loss and press is one exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            restart_cnt <= '0;
        end else if ((cur_state == S_RUN) && (next_state != S_RUN) &&
                     (restart_cnt != {RESTART_CNT_W{1'b1}})) begin
            restart_cnt <= restart_cnt + RESTART_CNT_W'(1);
        end
    end
`else
    assign restart_cnt = '0;
`endif

    assign state = cur_state;

endmodule

// File: tb/tb_rst_seq.sv
// Directed self-checking bench for rst_seq with default parameters.
module tb_rst_seq;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       btn_n;
    logic       rst_out_n;
    logic       tick;
    logic [1:0] state;
    logic [7:0] restart_cnt;

    int n_compared;
    int n_mismatched;

`ifdef RST_SEQ_RESTART_CNT_EN
    localparam logic [7:0] EXP_ONE = 8'd1;
`else
    localparam logic [7:0] EXP_ONE = 8'd0;
`endif

    rst_seq dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .btn_n       (btn_n),
        .rst_out_n   (rst_out_n),
        .tick        (tick),
        .state       (state),
        .restart_cnt (restart_cnt)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset, set inputs, release between edges so the next edge is "edge 1".
    task automatic do_reset(input logic lock, input logic btn);
        rst        = 1'b0;
        pll_locked = lock;
        btn_n      = btn;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        pll_locked = 1'b0;
        btn_n      = 1'b1;
        #2;
        n_compared++;
        if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        n_compared++;
        if (rst_out_n !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_rst_out_n: got %b expected 0", rst_out_n); end
        n_compared++;
        if (tick !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
        n_compared++;
        if (restart_cnt !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_restart_cnt: got %0d expected 0", restart_cnt); end
    endtask

    task automatic test_powerup();
        int tick_cnt;
        do_reset(1'b1, 1'b1);
        n_compared++;
        if (state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL pwr_state_e0: got %0d expected 0", state); end
        step(1);
        n_compared++;
        if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL pwr_state_e1: got %0d expected 1", state); end
        step(8);
        n_compared++;
        if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL pwr_state_e9: got %0d expected 1", state); end
        step(1);
        n_compared++;
        if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL pwr_state_e10: got %0d expected 2", state); end
        step(31);
        n_compared++;
        if (rst_out_n !== 1'b0 || state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL pwr_e41: got rst_out_n=%b state=%0d expected 0/2", rst_out_n, state); end
        step(1);
        n_compared++;
        if (rst_out_n !== 1'b1 || state !== 2'd3) begin n_mismatched++; $display("[TB] FAIL pwr_e42: got rst_out_n=%b state=%0d expected 1/3", rst_out_n, state); end
        tick_cnt = 0;
        for (int i = 0; i < 999; i++) begin
            step(1);
            if (tick === 1'b1) tick_cnt++;
        end
        n_compared++;
        if (tick_cnt != 0) begin n_mismatched++; $display("[TB] FAIL pwr_early_tick: got %0d ticks expected 0", tick_cnt); end
        step(1);
        n_compared++;
        if (tick !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pwr_tick_e1042: got %b expected 1", tick); end
        step(1);
        n_compared++;
        if (tick !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pwr_tick_e1043: got %b expected 0", tick); end
    endtask

    // Continues from RUN left by test_powerup.
    task automatic test_lock_loss();
        int tick_cnt;
        pll_locked = 1'b0;
        step(2);
        n_compared++;
        if (rst_out_n !== 1'b1 || state !== 2'd3) begin n_mismatched++; $display("[TB] FAIL loss_e2: got rst_out_n=%b state=%0d expected 1/3", rst_out_n, state); end
        step(1);
        n_compared++;
        if (rst_out_n !== 1'b0 || state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL loss_e3: got rst_out_n=%b state=%0d expected 0/1", rst_out_n, state); end
        n_compared++;
        if (restart_cnt !== EXP_ONE) begin n_mismatched++; $display("[TB] FAIL loss_restart_cnt: got %0d expected %0d", restart_cnt, EXP_ONE); end
        tick_cnt = 0;
        for (int i = 0; i < 1100; i++) begin
            step(1);
            if (tick === 1'b1) tick_cnt++;
        end
        n_compared++;
        if (tick_cnt != 0) begin n_mismatched++; $display("[TB] FAIL loss_tick_stopped: got %0d ticks expected 0", tick_cnt); end
    endtask

    task automatic test_late_lock();
        do_reset(1'b0, 1'b1);
        step(20);
        n_compared++;
        if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL late_wait: got %0d expected 1", state); end
        pll_locked = 1'b1;
        step(41);
        n_compared++;
        if (rst_out_n !== 1'b0) begin n_mismatched++; $display("[TB] FAIL late_e41: got %b expected 0", rst_out_n); end
        step(1);
        n_compared++;
        if (rst_out_n !== 1'b1) begin n_mismatched++; $display("[TB] FAIL late_e42: got %b expected 1", rst_out_n); end
    endtask

    task automatic test_lock_glitch();
        do_reset(1'b1, 1'b1);
        step(7);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        n_compared++;
        if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL glitch_e10: got %0d expected 1", state); end
        step(7);
        n_compared++;
        if (state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL glitch_e17: got %0d expected 1", state); end
        step(1);
        n_compared++;
        if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL glitch_e18: got %0d expected 2", state); end
        step(31);
        n_compared++;
        if (rst_out_n !== 1'b0) begin n_mismatched++; $display("[TB] FAIL glitch_e49: got %b expected 0", rst_out_n); end
        step(1);
        n_compared++;
        if (rst_out_n !== 1'b1) begin n_mismatched++; $display("[TB] FAIL glitch_e50: got %b expected 1", rst_out_n); end
    endtask

    task automatic test_button_bounce();
        do_reset(1'b1, 1'b1);
        step(42);
        for (int i = 0; i < 8; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(5);
        end
        n_compared++;
        if (state !== 2'd3 || rst_out_n !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bounce_still_run: got state=%0d rst_out_n=%b expected 3/1", state, rst_out_n); end
        btn_n = 1'b0;
        step(18);
        n_compared++;
        if (state !== 2'd3) begin n_mismatched++; $display("[TB] FAIL bounce_e18: got %0d expected 3", state); end
        step(1);
        n_compared++;
        if (state !== 2'd1 || rst_out_n !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bounce_exit: got state=%0d rst_out_n=%b expected 1/0", state, rst_out_n); end
        n_compared++;
        if (restart_cnt !== EXP_ONE) begin n_mismatched++; $display("[TB] FAIL bounce_restart_cnt: got %0d expected %0d", restart_cnt, EXP_ONE); end
        step(5);
        btn_n = 1'b1;
        step(40);
        n_compared++;
        if (restart_cnt !== EXP_ONE) begin n_mismatched++; $display("[TB] FAIL bounce_single_exit: got %0d expected %0d", restart_cnt, EXP_ONE); end
    endtask

    task automatic test_short_press();
        do_reset(1'b1, 1'b1);
        step(42);
        btn_n = 1'b0;
        step(15);
        btn_n = 1'b1;
        step(30);
        n_compared++;
        if (state !== 2'd3 || rst_out_n !== 1'b1) begin n_mismatched++; $display("[TB] FAIL short_press: got state=%0d rst_out_n=%b expected 3/1", state, rst_out_n); end
        n_compared++;
        if (restart_cnt !== 8'd0) begin n_mismatched++; $display("[TB] FAIL short_restart_cnt: got %0d expected 0", restart_cnt); end
    endtask

    task automatic test_async_reset_hold();
        do_reset(1'b1, 1'b1);
        step(20);
        n_compared++;
        if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL async_pre: got %0d expected 2", state); end
        rst = 1'b0;
        #1;
        n_compared++;
        if (state !== 2'd0 || rst_out_n !== 1'b0 || tick !== 1'b0 || restart_cnt !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL async_clear: got state=%0d rst_out_n=%b tick=%b restart_cnt=%0d expected 0/0/0/0", state, rst_out_n, tick, restart_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(10);
        n_compared++;
        if (state !== 2'd2) begin n_mismatched++; $display("[TB] FAIL async_replay_e10: got %0d expected 2", state); end
        step(31);
        n_compared++;
        if (rst_out_n !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_replay_e41: got %b expected 0", rst_out_n); end
        step(1);
        n_compared++;
        if (rst_out_n !== 1'b1) begin n_mismatched++; $display("[TB] FAIL async_replay_e42: got %b expected 1", rst_out_n); end
    endtask

`ifdef RST_SEQ_RESTART_CNT_EN
    task automatic test_saturation();
        do_reset(1'b1, 1'b1);
        step(42);
        for (int i = 0; i < 257; i++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            step(42);
        end
        n_compared++;
        if (restart_cnt !== 8'd255) begin n_mismatched++; $display("[TB] FAIL sat_restart_cnt: got %0d expected 255", restart_cnt); end
        n_compared++;
        if (state !== 2'd3) begin n_mismatched++; $display("[TB] FAIL sat_state: got %0d expected 3", state); end
    endtask
`endif

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_powerup();
        test_lock_loss();
        test_late_lock();
        test_lock_glitch();
        test_button_bounce();
        test_short_press();
        test_async_reset_hold();
`ifdef RST_SEQ_RESTART_CNT_EN
        test_saturation();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
